// File: rtl/ant_net_driver.sv
// Pattern source for the antenna-characterisation nets: loads a seed, drives a
// selected pattern for a programmed number of cycles, pulses done, parks low.
module ant_net_driver #(
  parameter int              NETS      = 8,
  parameter int              CNT_W     = 16,
  parameter logic [NETS-1:0] LFSR_TAPS = NETS'('hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [NETS-1:0]  seed,
  input  logic [CNT_W-1:0] cycles,
  output logic             busy,
  output logic             done,
  output logic [NETS-1:0]  net_out,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_WALK   = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_LFSR   = 2'b11
  } mode_t;

  state_t             state_q;
  mode_t              mode_q;
  logic [NETS-1:0]    seed_q;
  logic [CNT_W-1:0]   cycles_q;
  logic [NETS-1:0]    net_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;

  logic [NETS-1:0]    net_d;
  logic [NETS-1:0]    seed_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               fb;

  // Pattern advance from the current net drive, selected by the captured mode.
  always_comb begin
    fb    = ^(net_q & LFSR_TAPS);
    net_d = net_q;
    case (mode_q)
      MODE_STATIC: net_d = net_q;
      MODE_WALK:   net_d = {net_q[NETS-2:0], net_q[NETS-1]};
      MODE_TOGGLE: net_d = ~net_q;
      MODE_LFSR:   net_d = {net_q[NETS-2:0], fb};
      default:     net_d = net_q;
    endcase
  end

  // An all-zero seed would lock walking-one and LFSR patterns at zero.
  always_comb begin
    seed_d = seed_q;
    if ((seed_q == '0) && ((mode_q == MODE_WALK) || (mode_q == MODE_LFSR)))
      seed_d = NETS'(1);
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_STATIC;
      seed_q   <= '0;
      cycles_q <= '0;
      net_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          net_q <= '0;
          if (start) begin
            mode_q   <= mode_t'(mode);
            seed_q   <= seed;
            cycles_q <= cycles;
            busy_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          net_q <= seed_d;
          cnt_q <= '0;
          if (cycles_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          net_q <= net_d;
          cnt_q <= cnt_d;
          if (cnt_d == cycles_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          net_q   <= '0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          net_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign net_out   = net_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_ant_net_driver.sv
// Scoreboard bench for ant_net_driver: each run pushes its expected per-cycle
// outputs, and a negedge monitor pops and compares them.
module tb_ant_net_driver;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic [15:0] cycles;
  logic        busy;
  logic        done;
  logic [7:0]  net_out;
  logic [15:0] cycle_cnt;

  typedef struct {
    logic [7:0]  net;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] lastCnt = 16'd0;

  ant_net_driver #(.NETS(8), .CNT_W(16), .LFSR_TAPS(8'hB8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .cycles    (cycles),
    .busy      (busy),
    .done      (done),
    .net_out   (net_out),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] modelNext(input logic [1:0] m, input logic [7:0] p);
    logic [7:0] taps;
    logic       fb;
    taps = 8'hB8;
    fb   = 1'b0;
    case (m)
      2'b00:   return p;
      2'b01:   return (p << 1) | (p >> 7);
      2'b10:   return ~p;
      default: begin
        for (int i = 0; i < 8; i++)
          if (taps[i]) fb = fb ^ p[i];
        return {p[6:0], fb};
      end
    endcase
  endfunction

  // Expected outputs sampled at each negedge from the start-capture edge on.
  task automatic pushRun(input logic [1:0] m, input logic [7:0] s, input logic [15:0] n);
    exp_t       e;
    logic [7:0] p;
    e = '{net: 8'h00, busy: 1'b1, done: 1'b0, cnt: lastCnt};
    expQ.push_back(e);
    p = s;
    if (p == 8'h00 && (m == 2'b01 || m == 2'b11)) p = 8'h01;
    for (int k = 0; k <= int'(n); k++) begin
      e = '{net: p, busy: (k < int'(n)), done: (k == int'(n)), cnt: 16'(k)};
      expQ.push_back(e);
      p = modelNext(m, p);
    end
    e = '{net: 8'h00, busy: 1'b0, done: 1'b0, cnt: n};
    expQ.push_back(e);
    lastCnt = n;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] s, input logic [15:0] n);
    @(negedge clk);
    #1;
    pushRun(m, s, n);
    mode   = m;
    seed   = s;
    cycles = n;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mode   = ~m;
    seed   = ~s;
    cycles = 16'hFFFF;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && expQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d expected entries still pending, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Scoreboard monitor: compares one expected entry per negedge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (net_out !== e.net) begin
        errors++;
        $display("[TB] FAIL sb_net_out: got %02h, required %02h", net_out, e.net);
      end
      checks++;
      if (busy !== e.busy) begin
        errors++;
        $display("[TB] FAIL sb_busy: got %b, required %b (net %02h)", busy, e.busy, e.net);
      end
      checks++;
      if (done !== e.done) begin
        errors++;
        $display("[TB] FAIL sb_done: got %b, required %b (net %02h)", done, e.done, e.net);
      end
      checks++;
      if (cycle_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL sb_cycle_cnt: got %0d, required %0d", cycle_cnt, e.cnt);
      end
    end
  end

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, done, net_out, cycle_cnt} !== 26'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b net=%02h cnt=%0d, required all 0",
               busy, done, net_out, cycle_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, net_out} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b net=%02h, required 0", busy, done, net_out);
    end
  endtask

  task automatic test_walking();
    applyStimulus(2'b01, 8'h01, 16'd3);
    waitDrain();
    repeat (3) @(negedge clk);
    checks++;
    if (cycle_cnt !== 16'd3 || net_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL walk_cnt_hold: got cnt=%0d net=%02h, required cnt=3 net=00", cycle_cnt, net_out);
    end
    applyStimulus(2'b01, 8'h80, 16'd2);
    waitDrain();
  endtask

  task automatic test_toggle();
    applyStimulus(2'b10, 8'hA5, 16'd2);
    waitDrain();
  endtask

  task automatic test_lfsr();
    applyStimulus(2'b11, 8'h01, 16'd4);
    waitDrain();
    applyStimulus(2'b11, 8'h00, 16'd20);
    waitDrain();
    applyStimulus(2'b01, 8'h00, 16'd2);
    waitDrain();
  endtask

  task automatic test_zero_cycles();
    applyStimulus(2'b00, 8'h3C, 16'd0);
    waitDrain();
    applyStimulus(2'b00, 8'h00, 16'd1);
    waitDrain();
  endtask

  task automatic test_start_ignored();
    applyStimulus(2'b11, 8'h5A, 16'd6);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    mode  = 2'b00;
    seed  = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDrain();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    #1;
    pushRun(2'b10, 8'h3C, 16'd2);
    pushRun(2'b01, 8'h80, 16'd1);
    mode   = 2'b10;
    seed   = 8'h3C;
    cycles = 16'd2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    mode   = 2'b01;
    seed   = 8'h80;
    cycles = 16'd1;
    repeat (5) @(posedge clk);
    #1;
    start  = 1'b0;
    waitDrain();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    #1;
    mode   = 2'b01;
    seed   = 8'h01;
    cycles = 16'd10;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cycle_cnt !== 16'd5 || busy !== 1'b1 || net_out !== 8'h20) begin
      errors++;
      $display("[TB] FAIL pre_reset_run: got cnt=%0d busy=%b net=%02h, required cnt=5 busy=1 net=20",
               cycle_cnt, busy, net_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, net_out, cycle_cnt} !== 26'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b net=%02h cnt=%0d, required all 0",
               busy, done, net_out, cycle_cnt);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_no_done: got done=%b, required 0", done);
      end
    end
    rst = 1'b0;
    lastCnt = 16'd0;
    applyStimulus(2'b01, 8'h01, 16'd10);
    waitDrain();
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 2'b00;
    seed   = 8'h00;
    cycles = 16'd0;
    test_reset();
    test_walking();
    test_toggle();
    test_lfsr();
    test_zero_cycles();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ant_net_driver.md
# ant_net_driver

Programmable pattern source that drives the long routed test nets of the antenna-characterisation structures in the 0.35 µm test chip. Each of these nets terminates on FILLANT-style diode sinks. On a start request from the test controller, the block loads a seed and drives a chosen pattern onto the nets for a programmed number of clock cycles. It then pulses `done` and parks all nets low so they discharge.

## Interface
Parameters:
- `NETS`, 8, number of driven nets; legal range 2..32.
- `CNT_W`, 16, width of the cycle counter and of `cycles`.
- `LFSR_TAPS`, 8'hB8, feedback tap mask used in LFSR mode; `NETS` bits wide.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: run request; sampled only in IDLE.
- `mode` in 2: pattern select. 00 static, 01 walking-one, 10 toggle-all, 11 LFSR.
- `seed` in `NETS`: initial net pattern.
- `cycles` in `CNT_W`: number of RUN cycles.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: single-cycle pulse in DONE.
- `net_out` out `NETS`: registered net drive.
- `cycle_cnt` out `CNT_W`: RUN cycles executed so far.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - `start`=1 → LOAD. `mode`, `seed` and `cycles` are captured on this same edge.
  - `start`=0 → stay in IDLE.
- LOAD (1 cycle):
  - `net_out` <= effective seed, `cycle_cnt` <= 0.
  - Captured `cycles`=0 → DONE. Otherwise → RUN.
- Effective seed:
  - Captured `seed`, except when `seed`=0 in walking-one or LFSR mode.
  - In that case the effective seed is 1, so the pattern cannot lock up.
- RUN, every cycle: `net_out` <= next(`net_out`), `cycle_cnt` <= `cycle_cnt`+1.
  - When the incremented count equals captured `cycles`, the next state is DONE.
- next() by mode:
  - static: hold.
  - walking-one: rotate left by 1; MSB wraps to bit 0.
  - toggle-all: bitwise invert.
  - LFSR: fb = XOR-reduce(`net_out` & `LFSR_TAPS`); next = {`net_out`[NETS-2:0], fb}.
- DONE (1 cycle):
  - `done`=1; `net_out` and `cycle_cnt` hold.
  - Next state IDLE; `net_out` <= 0 on that edge.
- IDLE holds `net_out`=0. `cycle_cnt` holds its last value so the controller can read it back.
- `start` is ignored outside IDLE. Inputs may change freely after capture.
- `cycle_cnt` does not overflow: at most `cycles` ≤ 2^CNT_W−1 increments occur.

## Timing
- Reset values: state IDLE; `net_out`=0, `cycle_cnt`=0, `busy`=0, `done`=0. All outputs clear immediately on `rst` assertion, independent of `clk`.
- All outputs are registered. `busy` and `done` decode the registered state with no combinational path from inputs.
- `start` seen at edge t0:
  - LOAD during t0..t1; `busy`=1 from t0.
  - `net_out`=seed after edge t1.
  - With N=`cycles`>0: RUN spans N cycles, with N pattern advances after edges t2..t(N+1).
  - DONE during t(N+1)..t(N+2); IDLE with `net_out`=0 after edge t(N+2).
- Total busy+done span is N+2 cycles. With `cycles`=0 it is 2 cycles, and the seed is still driven for the DONE cycle.
- Back-to-back: `start` held high through DONE is accepted on the first IDLE cycle, so there is a 1-cycle IDLE gap with `net_out`=0.
- Reset mid-RUN: abort immediately, nets low, no `done` pulse.

## Test plan
- Walking-one, `seed`=8'h01, `cycles`=3 → `net_out` 01, 02, 04, 08; `done` pulses once; then 00. `cycle_cnt`=3 is held. `busy` is high for 4 cycles.
- Toggle-all, `seed`=8'hA5, `cycles`=2 → A5, 5A, A5; `done` pulse; then 00.
- LFSR, `seed`=8'h01, `cycles`=4, taps B8 → 01, 02, 04, 08, 11. LFSR with `seed`=0 → starts at 01.
- `cycles`=0, static, `seed`=8'h3C → 3C for exactly 1 cycle in DONE, `done`=1, `cycle_cnt`=0, then 00. Walking-one with `seed`=8'h80 wraps to 01.
- `start` pulsed during RUN with changed `seed` and `mode` → ignored; the original sequence completes unchanged.
- `rst` asserted asynchronously in RUN, cycle 5 of 10 → `net_out`, `busy` and `cycle_cnt` go to 0 without waiting for a clock edge. No `done` pulse. The next `start` runs a normal full sequence.
